// File: rtl/udp_frame_builder.sv
// Captures one UDP payload burst, computes the IPv4 header checksum and streams an
// Ethernet II + IPv4 + UDP frame (no FCS) to the MAC. Optional macro: FRAME_PAD_EN.
module udp_frame_builder #(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
  parameter logic [31:0] DST_IP      = 32'hC0A80164,
  parameter logic [15:0] SRC_PORT    = 16'd1234,
  parameter logic [15:0] DST_PORT    = 16'd5678,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter int          MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] udp_data,
  input  logic       udp_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic       drop
);
  localparam int          AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] HDR_LEN = 16'd42;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_CSUM,
    S_HDR,
`ifdef FRAME_PAD_EN
    S_PAD,
`endif
    S_PAYLOAD
  } state_t;

  state_t         r_state, w_state_nxt, w_tx_state;
  logic [7:0]     r_buf [MAX_PAYLOAD];
  logic [15:0]    r_len, w_len_nxt;
  logic [3:0]     r_cnt, w_cnt_nxt;
  logic [19:0]    r_sum, w_sum_nxt, w_sum_acc;
  logic [15:0]    r_csum, w_csum_nxt;
  logic [15:0]    r_idx, w_idx_nxt;
  logic [7:0]     r_tx_data, w_tx_data_nxt;
  logic           r_tx_valid, w_tx_valid_nxt;
  logic           r_tx_last, w_tx_last_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_drop, w_drop_nxt;
  logic           r_skip, w_skip_nxt;
  logic           w_wr_en;
  logic [AW-1:0]  w_wr_addr, w_pay_off;
  logic [15:0]    w_tot, w_udp, w_pay_end, w_frame_len, w_sel;
  logic [335:0]   w_hdr, w_hdr_sh;
  logic [7:0]     w_byte;

  function automatic logic [15:0] ip_word(input logic [3:0] i, input logic [15:0] tot);
    case (i)
      4'd0:    ip_word = 16'h4500;
      4'd1:    ip_word = tot;
      4'd2:    ip_word = 16'h0000;
      4'd3:    ip_word = 16'h4000;
      4'd4:    ip_word = {TTL, 8'h11};
      4'd5:    ip_word = 16'h0000;
      4'd6:    ip_word = SRC_IP[31:16];
      4'd7:    ip_word = SRC_IP[15:0];
      4'd8:    ip_word = DST_IP[31:16];
      4'd9:    ip_word = DST_IP[15:0];
      default: ip_word = 16'h0000;
    endcase
  endfunction

  // Ten 16-bit words sum below 2^20, so two end-around folds always suffice.
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    csum_fold = ~(t[15:0] + {15'd0, t[16]});
  endfunction

  assign w_tot     = 16'd28 + r_len;
  assign w_udp     = 16'd8 + r_len;
  assign w_pay_end = HDR_LEN + r_len;
`ifdef FRAME_PAD_EN
  assign w_frame_len = (w_pay_end < 16'd60) ? 16'd60 : w_pay_end;
`else
  assign w_frame_len = w_pay_end;
`endif
  assign w_sum_acc = r_sum + {4'd0, ip_word(r_cnt, w_tot)};
  assign w_hdr = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, w_tot, 16'h0000, 16'h4000,
                  TTL, 8'h11, r_csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, w_udp, 16'h0000};
  // Index of the byte to load next: byte 0 when leaving CSUM, else the successor.
  assign w_sel     = (r_state == S_CSUM) ? 16'd0 : r_idx + 16'd1;
  assign w_hdr_sh  = w_hdr << {w_sel, 3'b000};
  assign w_pay_off = AW'(w_sel - HDR_LEN);
  assign w_byte    = (w_sel < HDR_LEN) ? w_hdr_sh[335:328] :
                     (w_sel < w_pay_end) ? r_buf[w_pay_off] : 8'h00;

  // Frame section that the next loaded byte belongs to
  always_comb begin
    if (w_sel < HDR_LEN) begin
      w_tx_state = S_HDR;
`ifdef FRAME_PAD_EN
    end else if (w_sel >= w_pay_end) begin
      w_tx_state = S_PAD;
`endif
    end else begin
      w_tx_state = S_PAYLOAD;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_sum_nxt      = r_sum;
    w_csum_nxt     = r_csum;
    w_idx_nxt      = r_idx;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_last_nxt  = r_tx_last;
    w_busy_nxt     = r_busy;
    w_drop_nxt     = 1'b0;
    w_skip_nxt     = r_skip;
    w_wr_en        = 1'b0;
    w_wr_addr      = '0;
    case (r_state)
      S_IDLE: begin
        if (udp_valid && r_skip) begin
          w_drop_nxt = 1'b1;
        end else if (udp_valid) begin
          w_wr_en     = 1'b1;
          w_len_nxt   = 16'd1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_skip_nxt = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (udp_valid) begin
          if (r_len < MAX_LEN) begin
            w_wr_en   = 1'b1;
            w_wr_addr = AW'(r_len);
            w_len_nxt = r_len + 16'd1;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt   = 4'd0;
          w_sum_nxt   = 20'd0;
          w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        w_drop_nxt = udp_valid;
        w_skip_nxt = udp_valid;
        if (r_cnt == 4'd9) begin
          w_csum_nxt     = csum_fold(w_sum_acc);
          w_idx_nxt      = 16'd0;
          w_tx_data_nxt  = w_byte;
          w_tx_valid_nxt = 1'b1;
          w_tx_last_nxt  = 1'b0;
          w_state_nxt    = S_HDR;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_sum_nxt = w_sum_acc;
        end
      end
      S_HDR,
`ifdef FRAME_PAD_EN
      S_PAD,
`endif
      S_PAYLOAD: begin
        w_drop_nxt = udp_valid;
        w_skip_nxt = udp_valid;
        if (r_tx_valid && tx_ready && r_tx_last) begin
          w_tx_data_nxt  = 8'h00;
          w_tx_valid_nxt = 1'b0;
          w_tx_last_nxt  = 1'b0;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = S_IDLE;
        end else if (r_tx_valid && tx_ready) begin
          w_idx_nxt     = w_sel;
          w_tx_data_nxt = w_byte;
          w_tx_last_nxt = (w_sel == w_frame_len - 16'd1);
          w_state_nxt   = w_tx_state;
        end else begin
          w_tx_data_nxt = r_tx_data;
        end
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_tx_last_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  // Payload buffer write port
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_addr] <= udp_data;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= 16'd0;
      r_cnt      <= 4'd0;
      r_sum      <= 20'd0;
      r_csum     <= 16'd0;
      r_idx      <= 16'd0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
      r_skip     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sum      <= w_sum_nxt;
      r_csum     <= w_csum_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_last  <= w_tx_last_nxt;
      r_busy     <= w_busy_nxt;
      r_drop     <= w_drop_nxt;
      r_skip     <= w_skip_nxt;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign busy     = r_busy;
  assign drop     = r_drop;
endmodule
